// File: rtl/alu_issue_seq.sv
// Issue/retire sequencer driving a 32-bit ALU: decodes an instruction, registers ALU inputs,
// captures result/flags one cycle later and returns the response over a valid/ready handshake.
module alu_issue_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_v,
    input  logic            alu_c,
    input  logic            alu_z,
    input  logic            alu_n,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_branch_taken,
    output logic            out_illegal
);

    localparam logic [2:0] CtrlAdd = 3'b000;
    localparam logic [2:0] CtrlSub = 3'b001;
    localparam logic [2:0] CtrlAnd = 3'b010;
    localparam logic [2:0] CtrlOr  = 3'b011;
    localparam logic [2:0] CtrlSlt = 3'b101;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e     state_q, state_d;
    logic [2:0] dec_ctrl;
    logic       dec_illegal;
    logic       dec_branch;
    logic [2:0] br_sel_q;
    logic       is_branch_q;
    logic       illegal_q;
    logic       taken;

    always_comb begin
        dec_ctrl    = CtrlAdd;
        dec_illegal = 1'b0;
        dec_branch  = 1'b0;
        case (opcode)
            7'b0110011, 7'b0010011: begin
                case (funct3)
                    3'b000:  dec_ctrl = (funct7_5 && opcode[5]) ? CtrlSub : CtrlAdd;
                    3'b111:  dec_ctrl = CtrlAnd;
                    3'b110:  dec_ctrl = CtrlOr;
                    3'b010:  dec_ctrl = CtrlSlt;
                    default: dec_illegal = 1'b1;
                endcase
            end
            7'b0000011, 7'b0100011: dec_ctrl = CtrlAdd;
            7'b1100011: begin
                dec_ctrl    = CtrlSub;
                dec_branch  = 1'b1;
                dec_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_ctrl = CtrlAdd;
        end
    end

    // Flags are only meaningful during EXEC, when the ALU sees the registered operands.
    always_comb begin
        taken = 1'b0;
        if (is_branch_q && !illegal_q) begin
            case (br_sel_q)
                3'b000:  taken = alu_z;
                3'b001:  taken = ~alu_z;
                3'b100:  taken = alu_n ^ alu_v;
                3'b101:  taken = ~(alu_n ^ alu_v);
                3'b110:  taken = ~alu_c;
                3'b111:  taken = alu_c;
                default: taken = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = StExec;
                end
            end
            StExec: state_d = StDone;
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a            <= '0;
            alu_b            <= '0;
            alu_ctrl         <= CtrlAdd;
            br_sel_q         <= 3'b000;
            is_branch_q      <= 1'b0;
            illegal_q        <= 1'b0;
            out_result       <= '0;
            out_branch_taken <= 1'b0;
            out_illegal      <= 1'b0;
        end else begin
            if (state_q == StIdle && in_valid) begin
                alu_a       <= op_a;
                alu_b       <= op_b;
                alu_ctrl    <= dec_ctrl;
                br_sel_q    <= funct3;
                is_branch_q <= dec_branch;
                illegal_q   <= dec_illegal;
            end
            if (state_q == StExec) begin
                out_result       <= illegal_q ? '0 : alu_result;
                out_branch_taken <= taken;
                out_illegal      <= illegal_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Scoreboard bench for alu_issue_seq: a behavioural ALU closes the loop, directed vectors
// push expected responses, and a negedge monitor pops and compares on each handshake.
module tb_alu_issue_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_v, alu_c, alu_z, alu_n;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_branch_taken;
    logic        out_illegal;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        taken;
        logic        ill;
        logic [2:0]  ctrl;
        string       name;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    alu_issue_seq #(.XLEN(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .op_a             (op_a),
        .op_b             (op_b),
        .opcode           (opcode),
        .funct3           (funct3),
        .funct7_5         (funct7_5),
        .alu_a            (alu_a),
        .alu_b            (alu_b),
        .alu_ctrl         (alu_ctrl),
        .alu_result       (alu_result),
        .alu_v            (alu_v),
        .alu_c            (alu_c),
        .alu_z            (alu_z),
        .alu_n            (alu_n),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_result       (out_result),
        .out_branch_taken (out_branch_taken),
        .out_illegal      (out_illegal)
    );

    // Behavioural ALU; C is carry-out of A + ~B + 1 for sub (1 = no borrow).
    logic [32:0] sum33;
    always_comb begin
        sum33      = 33'd0;
        alu_result = 32'd0;
        alu_v      = 1'b0;
        alu_c      = 1'b0;
        case (alu_ctrl)
            3'b000: begin
                sum33      = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = sum33[31:0];
                alu_c      = sum33[32];
                alu_v      = (alu_a[31] == alu_b[31]) && (sum33[31] != alu_a[31]);
            end
            3'b001: begin
                sum33      = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_result = sum33[31:0];
                alu_c      = sum33[32];
                alu_v      = (alu_a[31] != alu_b[31]) && (sum33[31] != alu_a[31]);
            end
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b101:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = 32'd0;
        endcase
        alu_z = (alu_result == 32'd0);
        alu_n = alu_result[31];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
            end else if (out_ready) begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, out_result, e.res);
                check({e.name, "_taken"}, {31'd0, out_branch_taken}, {31'd0, e.taken});
                check({e.name, "_illegal"}, {31'd0, out_illegal}, {31'd0, e.ill});
                check({e.name, "_ctrl"}, {29'd0, alu_ctrl}, {29'd0, e.ctrl});
            end
        end
    end

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                          input logic [31:0] e_res, input logic e_taken, input logic e_ill,
                          input logic [2:0] e_ctrl, input int hold);
        exp_t e;
        @(posedge clk); #1;
        op_a = a; op_b = b; opcode = opc; funct3 = f3; funct7_5 = f7;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(negedge clk);
        check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        e.res = e_res; e.taken = e_taken; e.ill = e_ill; e.ctrl = e_ctrl; e.name = name;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({name, "_exec_valid"}, {31'd0, out_valid}, 32'd0);
        check({name, "_exec_alu_a"}, alu_a, a);
        @(negedge clk);
        check({name, "_lat_valid"}, {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({name, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
            check({name, "_hold_result"}, out_result, e_res);
            check({name, "_hold_alu_b"}, alu_b, b);
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        check({name, "_ret_valid"}, {31'd0, out_valid}, 32'd0);
        check({name, "_ret_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op_a = '0; op_b = '0; opcode = '0; funct3 = '0; funct7_5 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op("r_add",  32'h5, 32'h3, 7'b0110011, 3'b000, 1'b0, 32'h8, 1'b0, 1'b0, 3'b000, 0);
        run_op("r_sub",  32'h8000_0000, 32'h1, 7'b0110011, 3'b000, 1'b1,
               32'h7FFF_FFFF, 1'b0, 1'b0, 3'b001, 0);
        run_op("blt",    32'hFFFF_FFFF, 32'h1, 7'b1100011, 3'b100, 1'b0,
               32'hFFFF_FFFE, 1'b1, 1'b0, 3'b001, 0);
        run_op("bltu",   32'hFFFF_FFFF, 32'h1, 7'b1100011, 3'b110, 1'b0,
               32'hFFFF_FFFE, 1'b0, 1'b0, 3'b001, 0);
        run_op("bgeu",   32'hFFFF_FFFF, 32'h1, 7'b1100011, 3'b111, 1'b0,
               32'hFFFF_FFFE, 1'b1, 1'b0, 3'b001, 0);
        run_op("bge",    32'hFFFF_FFFF, 32'h1, 7'b1100011, 3'b101, 1'b0,
               32'hFFFF_FFFE, 1'b0, 1'b0, 3'b001, 0);
        run_op("beq",    32'h1234_5678, 32'h1234_5678, 7'b1100011, 3'b000, 1'b0,
               32'h0, 1'b1, 1'b0, 3'b001, 0);
        run_op("bne",    32'h5, 32'h5, 7'b1100011, 3'b001, 1'b0, 32'h0, 1'b0, 1'b0, 3'b001, 0);
        run_op("br_ill", 32'h5, 32'h3, 7'b1100011, 3'b010, 1'b0, 32'h0, 1'b0, 1'b1, 3'b000, 0);
        run_op("lui_ill", 32'h5, 32'h3, 7'b0110111, 3'b000, 1'b0, 32'h0, 1'b0, 1'b1, 3'b000, 0);
        run_op("r_f3_ill", 32'h5, 32'h3, 7'b0110011, 3'b001, 1'b0, 32'h0, 1'b0, 1'b1, 3'b000, 0);
        run_op("andi",   32'h0000_F0F0, 32'h0000_FF00, 7'b0010011, 3'b111, 1'b0,
               32'h0000_F000, 1'b0, 1'b0, 3'b010, 0);
        run_op("addi_f7", 32'h10, 32'h1, 7'b0010011, 3'b000, 1'b1, 32'h11, 1'b0, 1'b0, 3'b000, 0);
        run_op("r_slt",  32'hFFFF_FFFF, 32'h1, 7'b0110011, 3'b010, 1'b0,
               32'h1, 1'b0, 1'b0, 3'b101, 0);
        run_op("slti",   32'h5, 32'h3, 7'b0010011, 3'b010, 1'b1, 32'h0, 1'b0, 1'b0, 3'b101, 0);
        run_op("load",   32'h1000, 32'hFFFF_FFFC, 7'b0000011, 3'b010, 1'b0,
               32'h0FFC, 1'b0, 1'b0, 3'b000, 0);
        run_op("r_or_bp", 32'h0F, 32'hF0, 7'b0110011, 3'b110, 1'b0,
               32'hFF, 1'b0, 1'b0, 3'b011, 5);

        // Reset during EXEC: the addi must vanish without a response.
        @(posedge clk); #1;
        op_a = 32'h8; op_b = 32'h8; opcode = 7'b0010011; funct3 = 3'b000; funct7_5 = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstx_out_valid", {31'd0, out_valid}, 32'd0);
        check("rstx_in_ready", {31'd0, in_ready}, 32'd1);
        check("rstx_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
        check("rstx_out_result", out_result, 32'd0);
        check("rstx_alu_a", alu_a, 32'd0);

        // Reset together with in_valid: request must not be taken.
        @(posedge clk); #1;
        op_a = 32'h77; in_valid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("rstv_in_ready", {31'd0, in_ready}, 32'd1);
        check("rstv_alu_a", alu_a, 32'd0);

        repeat (6) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
